// File: rtl/sample_stream_pkg.sv
// Shared types and constants for the sample stream arbiter and its helpers.
// State encoding is fixed so the FSM can be inspected in waveforms by value.
package sample_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Header word that acquisition peripherals place at the start of a packet.
  localparam logic [31:0] SAMPLE_TYPE = 32'h5350_0000;

  function automatic int unsigned wrapAdd(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned modulus);
    return (base + offset) % modulus;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin search: finds the first requester after the
// previous grant, wrapping around, with the previous grant itself last.
module rr_priority_select
  import sample_stream_pkg::*;
#(
  parameter int N_SOURCES = 4
) (
  input  logic [N_SOURCES-1:0]         i_req,
  input  logic [$clog2(N_SOURCES)-1:0] i_lastGrant,
  output logic                         o_found,
  output logic [$clog2(N_SOURCES)-1:0] o_index
);

  localparam int IW = $clog2(N_SOURCES);

  logic [IW-1:0] w_cand;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = '0;
    for (int k = N_SOURCES; k >= 1; k--) begin
      w_cand = IW'(wrapAdd(32'(i_lastGrant), 32'(k), 32'(N_SOURCES)));
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_index = w_cand;
      end
    end
  end

endmodule

// File: rtl/sample_stream_arbiter.sv
// Merges whole AXI-stream packets from several sources round-robin into one
// output stream, cutting runaway packets at a length limit with a sticky fault.
module sample_stream_arbiter
  import sample_stream_pkg::*;
#(
  parameter int N_SOURCES            = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_PACKET_WORDS     = 16
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   run,
  input  logic [N_SOURCES-1:0]                   s_axis_tvalid,
  input  logic [N_SOURCES*C_M_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N_SOURCES-1:0]                   s_axis_tlast,
  output logic [N_SOURCES-1:0]                   s_axis_tready,
  output logic                                   m_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]        m_axis_tdata,
  output logic                                   m_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]      m_axis_tstrb,
  input  logic                                   m_axis_tready,
  output logic                                   busy,
  output logic                                   fault
);

  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int IW = $clog2(N_SOURCES);
  localparam int CW = $clog2(MAX_PACKET_WORDS + 1);

  state_t          r_state;
  logic [IW-1:0]   r_grant;
  logic [IW-1:0]   r_lastGrant;
  logic [CW-1:0]   r_count;
  logic            r_mTvalid;
  logic [W-1:0]    r_mTdata;
  logic            r_mTlast;
  logic            r_busy;
  logic            r_fault;

  logic            w_reqFound;
  logic [IW-1:0]   w_reqIndex;
  logic            w_selValid;
  logic [W-1:0]    w_selData;
  logic            w_selLast;
  logic            w_srcReady;
  logic            w_accept;
  logic [CW-1:0]   w_countNext;
  logic            w_limitHit;

  rr_priority_select #(
    .N_SOURCES(N_SOURCES)
  ) u_select (
    .i_req      (s_axis_tvalid),
    .i_lastGrant(r_lastGrant),
    .o_found    (w_reqFound),
    .o_index    (w_reqIndex)
  );

  // The output register accepts a new word whenever it is empty or draining.
  assign w_selValid  = s_axis_tvalid[r_grant];
  assign w_selData   = s_axis_tdata[r_grant*W +: W];
  assign w_selLast   = s_axis_tlast[r_grant];
  assign w_srcReady  = (r_state == S_PASS) && (!r_mTvalid || m_axis_tready);
  assign w_accept    = w_srcReady && w_selValid;
  assign w_countNext = r_count + 1'b1;
  assign w_limitHit  = !w_selLast && (w_countNext == CW'(MAX_PACKET_WORDS));

  always_comb begin
    s_axis_tready          = '0;
    s_axis_tready[r_grant] = w_srcReady;
  end

  // Arbitration FSM and output register share one clocked process so that
  // the forced tlast and the fault flag land on the same edge as the word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_lastGrant <= IW'(N_SOURCES - 1);
      r_count     <= '0;
      r_mTvalid   <= 1'b0;
      r_mTdata    <= '0;
      r_mTlast    <= 1'b0;
      r_busy      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mTvalid <= 1'b1;
        r_mTdata  <= w_selData;
        r_mTlast  <= w_selLast || w_limitHit;
      end else if (m_axis_tready && r_mTvalid) begin
        r_mTvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (run && w_reqFound) begin
            r_grant <= w_reqIndex;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_accept) begin
            r_count <= w_countNext;
            if (w_selLast) begin
              r_lastGrant <= r_grant;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end else if (w_limitHit) begin
              r_fault <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          if (!run) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign m_axis_tvalid = r_mTvalid;
  assign m_axis_tdata  = r_mTdata;
  assign m_axis_tlast  = r_mTlast;
  assign m_axis_tstrb  = '1;
  assign busy          = r_busy;
  assign fault         = r_fault;

endmodule

// File: tb/tb_sample_stream_arbiter.sv
// Directed bench for sample_stream_arbiter: a queue-based source model per
// input, an output capture queue, and hand-computed expected words.
module tb_sample_stream_arbiter;
  import sample_stream_pkg::*;

  localparam int NS   = 4;
  localparam int W    = 32;
  localparam int MAXW = 16;

  logic              clk;
  logic              resetn;
  logic              run;
  logic [NS-1:0]     s_axis_tvalid;
  logic [NS*W-1:0]   s_axis_tdata;
  logic [NS-1:0]     s_axis_tlast;
  logic [NS-1:0]     s_axis_tready;
  logic              m_axis_tvalid;
  logic [W-1:0]      m_axis_tdata;
  logic              m_axis_tlast;
  logic [W/8-1:0]    m_axis_tstrb;
  logic              m_axis_tready;
  logic              busy;
  logic              fault;

  logic [W-1:0]      srcData [NS][32];
  logic              srcLast [NS][32];
  int                srcLen  [NS];
  int                srcPtr  [NS];
  logic [NS-1:0]     srcEn;
  logic [NS-1:0]     srcFire;

  logic [W-1:0]      outData [$];
  logic              outLast [$];

  logic              stallPending;
  logic [W:0]        stallWord;
  logic              bpOn;
  int                bpCycle;
  logic [3:0]        bpPattern;

  int                assertCount;
  int                failCount;

  sample_stream_arbiter #(
    .N_SOURCES           (NS),
    .C_M_AXIS_TDATA_WIDTH(W),
    .MAX_PACKET_WORDS    (MAXW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tstrb (m_axis_tstrb),
    .m_axis_tready(m_axis_tready),
    .busy         (busy),
    .fault        (fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Sources present their current word; the pointer moves only on a handshake.
  task automatic applyStimulus();
    for (int i = 0; i < NS; i++) begin
      if (srcEn[i] && srcPtr[i] < srcLen[i]) begin
        s_axis_tvalid[i]        = 1'b1;
        s_axis_tdata[i*W +: W]  = srcData[i][srcPtr[i]];
        s_axis_tlast[i]         = srcLast[i][srcPtr[i]];
      end else begin
        s_axis_tvalid[i]        = 1'b0;
        s_axis_tdata[i*W +: W]  = '0;
        s_axis_tlast[i]         = 1'b0;
      end
    end
  endtask

  task automatic loadPacket(input int src, input int n, input logic [W-1:0] base,
                            input bit withLast);
    for (int j = 0; j < n; j++) begin
      srcData[src][j] = base + W'(j);
      srcLast[src][j] = withLast && (j == n - 1);
    end
    srcLen[src] = n;
    srcPtr[src] = 0;
    srcEn[src]  = 1'b1;
  endtask

  // One clock: observe on the falling edge, update stimulus just after rising.
  task automatic tick();
    @(negedge clk);
    if (stallPending)
      checkOutput("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                  64'({1'b1, stallWord}));
    stallPending = m_axis_tvalid && !m_axis_tready;
    stallWord    = {m_axis_tlast, m_axis_tdata};
    for (int i = 0; i < NS; i++) srcFire[i] = s_axis_tvalid[i] && s_axis_tready[i];
    if (m_axis_tvalid && m_axis_tready) begin
      outData.push_back(m_axis_tdata);
      outLast.push_back(m_axis_tlast);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (srcFire[i]) srcPtr[i]++;
    if (bpOn) begin
      m_axis_tready = bpPattern[2'(bpCycle % 4)];
      bpCycle++;
    end
    applyStimulus();
  endtask

  task automatic waitWords(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (outData.size() < n && c < budget) begin
      tick();
      c++;
    end
    checkOutput(tag, 64'(outData.size()), 64'(n));
  endtask

  task automatic checkWord(input string tag, input int idx, input logic [W-1:0] expData,
                           input logic expLast);
    logic [63:0] obs;
    if (idx < outData.size()) obs = 64'({outLast[idx], outData[idx]});
    else obs = '1;
    checkOutput(tag, obs, 64'({expLast, expData}));
  endtask

  task automatic clearOutputs();
    outData.delete();
    outLast.delete();
  endtask

  initial begin
    logic [W-1:0] exp1 [5];
    int order [3];
    assertCount   = 0;
    failCount     = 0;
    resetn        = 1'b0;
    run           = 1'b0;
    m_axis_tready = 1'b1;
    srcEn         = '0;
    srcFire       = '0;
    stallPending  = 1'b0;
    stallWord     = '0;
    bpOn          = 1'b0;
    bpCycle       = 0;
    bpPattern     = 4'b1001;
    for (int i = 0; i < NS; i++) begin
      srcLen[i] = 0;
      srcPtr[i] = 0;
    end
    applyStimulus();

    repeat (2) tick();
    checkOutput("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("rst_tdata",  64'(m_axis_tdata),  64'(0));
    checkOutput("rst_tlast",  64'(m_axis_tlast),  64'(0));
    checkOutput("rst_tready", 64'(s_axis_tready), 64'(0));
    checkOutput("rst_busy",   64'(busy),          64'(0));
    checkOutput("rst_fault",  64'(fault),         64'(0));
    checkOutput("rst_tstrb",  64'(m_axis_tstrb),  64'(4'hF));
    resetn = 1'b1;
    tick();

    $display("[TB] single source, steady drain");
    exp1[0] = SAMPLE_TYPE; exp1[1] = 32'h14; exp1[2] = 32'h1234;
    exp1[3] = 32'h0;       exp1[4] = 32'h10001;
    run = 1'b1;
    loadPacket(1, 5, '0, 1'b1);
    for (int j = 0; j < 5; j++) srcData[1][j] = exp1[j];
    applyStimulus();
    tick();
    checkOutput("t1_grant_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("t1_grant_busy",   64'(busy),          64'(1));
    checkOutput("t1_grant_tready", 64'(s_axis_tready), 64'(4'b0010));
    tick();
    checkOutput("t1_first_tvalid", 64'(m_axis_tvalid), 64'(1));
    checkOutput("t1_first_tdata",  64'(m_axis_tdata),  64'(SAMPLE_TYPE));
    waitWords(5, 20, "t1_count");
    for (int k = 0; k < 5; k++) checkWord("t1_word", k, exp1[k], k == 4);
    checkOutput("t1_idle_busy",   64'(busy),          64'(0));
    checkOutput("t1_idle_tvalid", 64'(m_axis_tvalid), 64'(0));

    $display("[TB] round-robin fairness");
    clearOutputs();
    resetn = 1'b0;
    loadPacket(0, 5, 32'hA000_0000, 1'b1);
    loadPacket(2, 5, 32'hA000_0200, 1'b1);
    loadPacket(3, 5, 32'hA000_0300, 1'b1);
    applyStimulus();
    tick();
    resetn = 1'b1;
    waitWords(15, 60, "t2_count");
    order[0] = 0; order[1] = 2; order[2] = 3;
    for (int k = 0; k < 15; k++)
      checkWord("t2_word", k, 32'hA000_0000 + W'(order[k / 5] * 256 + k % 5), (k % 5) == 4);
    clearOutputs();
    loadPacket(0, 2, 32'hB000_0000, 1'b1);
    loadPacket(1, 2, 32'hB000_0100, 1'b1);
    applyStimulus();
    waitWords(4, 30, "t2_rereq_count");
    checkWord("t2_rereq_w0", 0, 32'hB000_0000, 1'b0);
    checkWord("t2_rereq_w1", 1, 32'hB000_0001, 1'b1);
    checkWord("t2_rereq_w2", 2, 32'hB000_0100, 1'b0);
    checkWord("t2_rereq_w3", 3, 32'hB000_0101, 1'b1);

    $display("[TB] backpressure");
    clearOutputs();
    loadPacket(3, 8, 32'hC000_0000, 1'b1);
    bpOn    = 1'b1;
    bpCycle = 0;
    applyStimulus();
    waitWords(8, 60, "t3_count");
    bpOn = 1'b0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 8; k++) checkWord("t3_word", k, 32'hC000_0000 + W'(k), k == 7);
    repeat (2) tick();
    checkOutput("t3_drained", 64'(outData.size()), 64'(8));

    $display("[TB] length violation");
    clearOutputs();
    loadPacket(2, 20, 32'hD000_0000, 1'b0);
    applyStimulus();
    waitWords(16, 60, "t4_count");
    for (int k = 0; k < 16; k++) checkWord("t4_word", k, 32'hD000_0000 + W'(k), k == 15);
    checkOutput("t4_fault", 64'(fault), 64'(1));
    loadPacket(0, 3, 32'hE000_0000, 1'b1);
    applyStimulus();
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput("t4_hold_tready", 64'(s_axis_tready), 64'(0));
    end
    checkOutput("t4_no_extra", 64'(outData.size()), 64'(16));
    checkOutput("t4_busy", 64'(busy), 64'(0));
    srcEn[2] = 1'b0;
    applyStimulus();
    run = 1'b0;
    repeat (2) tick();
    run = 1'b1;
    waitWords(19, 30, "t4_resume_count");
    for (int k = 0; k < 3; k++) checkWord("t4_resume_word", 16 + k, 32'hE000_0000 + W'(k), k == 2);
    checkOutput("t4_fault_sticky", 64'(fault), 64'(1));

    $display("[TB] run drop and reset");
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checkOutput("t5_fault_cleared", 64'(fault), 64'(0));
    clearOutputs();
    loadPacket(1, 6, 32'h6000_0000, 1'b1);
    loadPacket(2, 4, 32'h7000_0000, 1'b1);
    applyStimulus();
    waitWords(3, 20, "t5_word3");
    run = 1'b0;
    waitWords(6, 20, "t5_complete");
    repeat (5) tick();
    checkOutput("t5_no_grant_count",  64'(outData.size()), 64'(6));
    checkOutput("t5_no_grant_busy",   64'(busy),           64'(0));
    checkOutput("t5_no_grant_tready", 64'(s_axis_tready),  64'(0));
    for (int k = 0; k < 6; k++) checkWord("t5_word", k, 32'h6000_0000 + W'(k), k == 5);
    clearOutputs();
    run = 1'b1;
    waitWords(2, 20, "t5_second_start");
    checkWord("t5_second_w0", 0, 32'h7000_0000, 1'b0);
    checkOutput("t5_pre_reset_tvalid", 64'(m_axis_tvalid), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("t5_async_tvalid", 64'(m_axis_tvalid), 64'(0));
    checkOutput("t5_async_tdata",  64'(m_axis_tdata),  64'(0));
    checkOutput("t5_async_tlast",  64'(m_axis_tlast),  64'(0));
    checkOutput("t5_async_tready", 64'(s_axis_tready), 64'(0));
    checkOutput("t5_async_busy",   64'(busy),          64'(0));
    checkOutput("t5_async_fault",  64'(fault),         64'(0));
    tick();
    resetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
